// File: rtl/act_reader.sv
// Activation reader: streams rd_len 256-bit beats from the ping-pong bank pair
// through a 2-entry skid FIFO onto a valid/ready output.
module act_reader #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_start,
  input  logic [LEN_W-1:0]    rd_len,
  output logic                busy,
  output logic                done,
  output logic                bre_0,
  output logic                bre_1,
  output logic                bre_2,
  output logic                bre_3,
  output logic [ADDR_W-1:0]   braddr_0,
  output logic [ADDR_W-1:0]   braddr_1,
  output logic [ADDR_W-1:0]   braddr_2,
  output logic [ADDR_W-1:0]   braddr_3,
  input  logic [DATA_W-1:0]   brdata_0,
  input  logic [DATA_W-1:0]   brdata_1,
  input  logic [DATA_W-1:0]   brdata_2,
  input  logic [DATA_W-1:0]   brdata_3,
  output logic [2*DATA_W-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready
);

  localparam int BEAT_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic                pp_q, pp_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic                inflight_q, inflight_d;
  logic [BEAT_W-1:0]   mem_q [2];
  logic [BEAT_W-1:0]   mem_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;

  logic                issue;
  logic                push;
  logic                pop;
  logic [1:0]          slots_used;
  logic [BEAT_W-1:0]   push_data;

  // A beat leaving the FIFO this cycle frees its slot for the read issued now,
  // which is what allows one beat per cycle with dout_ready held high.
  always_comb begin
    pop        = (count_q != 2'd0) && dout_ready;
    push       = inflight_q;
    slots_used = count_q - {1'b0, pop} + {1'b0, inflight_q};
    issue      = (state_q == READ) && (slots_used < 2'd2);
    push_data  = pp_q ? {brdata_3, brdata_2} : {brdata_1, brdata_0};
  end

  always_comb begin
    state_d    = state_q;
    pp_d       = pp_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    inflight_d = issue;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          len_d    = rd_len;
          addr_d   = '0;
          issued_d = '0;
          state_d  = (rd_len != '0) ? READ : DONE;
        end
      end
      READ: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + LEN_W'(1);
          if (issued_q + LEN_W'(1) == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (count_q == 2'd0)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (len_q != '0) pp_d = ~pp_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pp_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      pp_q       <= pp_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // The unselected pair is held at zero so the other side can own it freely.
  always_comb begin
    busy       = (state_q == READ) || (state_q == DRAIN);
    done       = (state_q == DONE);
    bre_0      = issue && !pp_q;
    bre_1      = issue && !pp_q;
    bre_2      = issue && pp_q;
    bre_3      = issue && pp_q;
    braddr_0   = pp_q ? '0 : addr_q;
    braddr_1   = pp_q ? '0 : addr_q;
    braddr_2   = pp_q ? addr_q : '0;
    braddr_3   = pp_q ? addr_q : '0;
    dout       = mem_q[rd_ptr_q];
    dout_valid = (count_q != 2'd0);
  end

endmodule

// File: tb/tb_act_reader.sv
// Scoreboard bench for act_reader: bank models answer reads one cycle later,
// expected beats are queued at rd_start and compared on each handshake.
module tb_act_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rd_start = 1'b0;
  logic [12:0]  rd_len = '0;
  logic         busy, done;
  logic         bre_0, bre_1, bre_2, bre_3;
  logic [14:0]  braddr_0, braddr_1, braddr_2, braddr_3;
  logic [127:0] brdata_0 = '0, brdata_1 = '0, brdata_2 = '0, brdata_3 = '0;
  logic [255:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b1;

  act_reader dut (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .rd_len(rd_len),
    .busy(busy), .done(done),
    .bre_0(bre_0), .bre_1(bre_1), .bre_2(bre_2), .bre_3(bre_3),
    .braddr_0(braddr_0), .braddr_1(braddr_1), .braddr_2(braddr_2), .braddr_3(braddr_3),
    .brdata_0(brdata_0), .brdata_1(brdata_1), .brdata_2(brdata_2), .brdata_3(brdata_3),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] bank_val(input int b, input int a);
    return 128'(b * 256 + a);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [255:0] sb[$];
  int           beats = 0, dones = 0, issues = 0;
  int           occ = 0, infl_m = 0;
  bit           stall_prev = 0;
  logic [255:0] held = '0;
  logic [14:0]  exp_addr = '0;
  bit           exp_pp = 0;
  bit           ready_mode = 0;
  int           pat_idx = 0;

  // Bank RAM model: data for a read enable seen in cycle t is driven during t+1.
  initial begin
    logic [3:0]  r;
    logic [14:0] a0, a1, a2, a3;
    forever begin
      @(negedge clk);
      r  = {bre_3, bre_2, bre_1, bre_0};
      a0 = braddr_0; a1 = braddr_1; a2 = braddr_2; a3 = braddr_3;
      @(posedge clk); #1;
      brdata_0 = r[0] ? bank_val(0, int'(a0)) : rnd128();
      brdata_1 = r[1] ? bank_val(1, int'(a1)) : rnd128();
      brdata_2 = r[2] ? bank_val(2, int'(a2)) : rnd128();
      brdata_3 = r[3] ? bank_val(3, int'(a3)) : rnd128();
    end
  end

  // Sink ready: always 1, or the repeating 1,0,0,1 pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      dout_ready = (ready_mode == 0) ? 1'b1 : ((pat_idx == 0) || (pat_idx == 3));
      pat_idx = (pat_idx + 1) % 4;
    end
  end

  // Output monitor; occ tracks beats captured but not yet accepted.
  initial begin
    bit pop, any_bre;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        occ = 0; infl_m = 0; stall_prev = 0;
      end else begin
        pop     = dout_valid && dout_ready;
        any_bre = bre_0 | bre_1 | bre_2 | bre_3;
        chk("valid_occ", dout_valid, occ != 0);
        if (stall_prev) begin
          chk("stall_valid", dout_valid, 1);
          chk("stall_data", dout, held);
        end
        if (pop) begin
          if (sb.size() == 0) chk("extra_beat", 1, 0);
          else chk("dout", dout, sb.pop_front());
          beats++;
        end
        if (any_bre) begin
          issues++;
          chk("issue_room", (occ - int'(pop) + infl_m) < 2, 1);
          if (!exp_pp) begin
            chk("bre_pair", {bre_3, bre_2, bre_1, bre_0}, 4'b0011);
            chk("raddr", {braddr_1, braddr_0}, {exp_addr, exp_addr});
            chk("unsel_addr", {braddr_3, braddr_2}, 0);
          end else begin
            chk("bre_pair", {bre_3, bre_2, bre_1, bre_0}, 4'b1100);
            chk("raddr", {braddr_3, braddr_2}, {exp_addr, exp_addr});
            chk("unsel_addr", {braddr_1, braddr_0}, 0);
          end
          exp_addr = exp_addr + 15'd1;
        end
        if (done) begin
          dones++;
          chk("busy_at_done", busy, 0);
        end
        occ        = occ - int'(pop) + infl_m;
        infl_m     = int'(any_bre);
        stall_prev = dout_valid && !dout_ready;
        held       = dout;
      end
    end
  end

  task automatic push_expected(input int len);
    exp_addr = '0;
    for (int a = 0; a < len; a++)
      sb.push_back(exp_pp ? {bank_val(3, a), bank_val(2, a)} : {bank_val(1, a), bank_val(0, a)});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {busy, done, dout_valid, bre_3, bre_2, bre_1, bre_0}, 0);
    chk({tag, "_addr"}, {braddr_3, braddr_2, braddr_1, braddr_0}, 0);
    chk({tag, "_dout"}, dout, 0);
  endtask

  task automatic xfer(input int len, input bit lat, input bit spur);
    int b0, d0, i0;
    bit seen;
    b0 = beats; d0 = dones; i0 = issues;
    push_expected(len);
    @(posedge clk); #1;
    rd_start = 1'b1; rd_len = 13'(len);
    @(posedge clk); #1;
    rd_start = 1'b0; rd_len = '0;
    if (lat) begin
      @(negedge clk); chk("lat0", dout_valid, 0); chk("busy_run", busy, 1);
      @(negedge clk); chk("lat1", dout_valid, 0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); chk("thru", dout_valid, 1);
      end
      @(negedge clk); chk("thru_end", dout_valid, 0);
    end
    if (len == 0) begin
      @(negedge clk); chk("done_len0", done, 1); chk("busy_len0", busy, 0);
      @(negedge clk); chk("done_once", done, 0);
    end
    if (spur) begin
      chk("busy_spur", busy, 1);
      rd_start = 1'b1; rd_len = 13'd5;
      @(posedge clk); #1;
      rd_start = 1'b0; rd_len = '0;
    end
    seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge clk);
      seen = (dones > d0);
    end
    if (!seen) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    chk("done_cnt", dones - d0, 1);
    chk("beats", beats - b0, len);
    chk("issues", issues - i0, len);
    chk("sb_empty", sb.size(), 0);
    if (len != 0) exp_pp = ~exp_pp;
  endtask

  initial begin
    int b0;
    bit hit;
    #12;
    check_reset_outputs("rst0");
    #11 rst_n = 1'b1;

    xfer(4, 1'b1, 1'b0);                 // pair 0/1, latency and full throughput
    xfer(2, 1'b0, 1'b0);                 // pair 2/3

    pat_idx = 0; ready_mode = 1'b1;      // stalled sink
    xfer(8, 1'b0, 1'b0);
    ready_mode = 1'b0;

    xfer(0, 1'b0, 1'b0);                 // empty transfer keeps pp at 1

    // Reset after two of six beats while reading pair 2/3.
    b0 = beats;
    push_expected(6);
    @(posedge clk); #1;
    rd_start = 1'b1; rd_len = 13'd6;
    @(posedge clk); #1;
    rd_start = 1'b0; rd_len = '0;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk);
      hit = (beats - b0 >= 2);
    end
    if (!hit) chk("mid_timeout", 0, 1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    sb.delete();
    exp_pp = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    xfer(1, 1'b0, 1'b0);                 // pp back to 0: bank 0/1 address 0

    xfer(3, 1'b0, 1'b1);                 // rd_start while busy is ignored

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
